// File: rtl/e203_clint_pkg.sv
// CLINT register map and the timer-arm sequencer state encoding.
// The offsets are shared with the CLINT responder.
package e203_clint_pkg;

  localparam logic [31:0] CLINT_MSIP_OFS        = 32'h0000_0000;
  localparam logic [31:0] CLINT_MTIMECMP_LO_OFS = 32'h0000_4000;
  localparam logic [31:0] CLINT_MTIMECMP_HI_OFS = 32'h0000_4004;
  localparam logic [31:0] CLINT_MTIME_LO_OFS    = 32'h0000_BFF8;
  localparam logic [31:0] CLINT_MTIME_HI_OFS    = 32'h0000_BFFC;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_RD_HI1     = 3'd1,
    ST_RD_LO      = 3'd2,
    ST_RD_HI2     = 3'd3,
    ST_WR_CLO_MAX = 3'd4,
    ST_WR_CHI     = 3'd5,
    ST_WR_CLO     = 3'd6,
    ST_DONE       = 3'd7
  } arm_state_e;

endpackage

// File: rtl/e203_icb_single_txn.sv
// Single-outstanding ICB transaction engine. A start pulse loads the command
// payload and raises cmd_valid; after the command handshake it waits in the
// response phase. fin/err/rdata are presented combinationally on the response
// handshake so the caller can launch the next command in the same cycle.
module e203_icb_single_txn (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic [31:0] addr_i,
  input  logic        read_i,
  input  logic [31:0] wdata_i,
  output logic        fin_o,
  output logic        err_o,
  output logic [31:0] rdata_o,
  output logic        icb_cmd_valid_o,
  input  logic        icb_cmd_ready_i,
  output logic [31:0] icb_cmd_addr_o,
  output logic        icb_cmd_read_o,
  output logic [31:0] icb_cmd_wdata_o,
  output logic [3:0]  icb_cmd_wmask_o,
  input  logic        icb_rsp_valid_i,
  output logic        icb_rsp_ready_o,
  input  logic        icb_rsp_err_i,
  input  logic [31:0] icb_rsp_rdata_i
);

  logic        cmd_valid_q;
  logic        rsp_phase_q;
  logic [31:0] addr_q;
  logic        read_q;
  logic [31:0] wdata_q;
  logic [3:0]  wmask_q;

  // responses outside the response phase are never accepted
  assign fin_o   = rsp_phase_q & icb_rsp_valid_i;
  assign err_o   = fin_o & icb_rsp_err_i;
  assign rdata_o = icb_rsp_rdata_i;

  assign icb_cmd_valid_o = cmd_valid_q;
  assign icb_cmd_addr_o  = addr_q;
  assign icb_cmd_read_o  = read_q;
  assign icb_cmd_wdata_o = wdata_q;
  assign icb_cmd_wmask_o = wmask_q;
  assign icb_rsp_ready_o = rsp_phase_q;

  // CMD/RSP phase tracking; payload only changes on start, so it holds while stalled
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cmd_valid_q <= 1'b0;
      rsp_phase_q <= 1'b0;
      addr_q      <= '0;
      read_q      <= 1'b1;
      wdata_q     <= '0;
      wmask_q     <= '0;
    end else begin
      if (cmd_valid_q && icb_cmd_ready_i) begin
        cmd_valid_q <= 1'b0;
        rsp_phase_q <= 1'b1;
      end
      if (fin_o) begin
        rsp_phase_q <= 1'b0;
      end
      if (start_i) begin
        cmd_valid_q <= 1'b1;
        addr_q      <= addr_i;
        read_q      <= read_i;
        wdata_q     <= read_i ? 32'h0 : wdata_i;
        wmask_q     <= read_i ? 4'h0 : 4'hF;
      end
    end
  end

endmodule

// File: rtl/e203_subsys_clint_tmr_arm.sv
// Arms the CLINT machine timer: samples 64-bit mtime consistently over the
// 32-bit ICB (hi/lo/hi with bounded re-sampling), then programs
// mtimecmp = mtime + interval with the lo=max, hi, lo write order so the
// comparator never sees a spurious early deadline.
//
// state         | meaning
// ST_IDLE       | waiting for arm request, arm_ready high
// ST_RD_HI1     | first read of mtime hi
// ST_RD_LO      | read of mtime lo
// ST_RD_HI2     | re-read of mtime hi to detect a lo carry
// ST_WR_CLO_MAX | park mtimecmp lo at all-ones
// ST_WR_CHI     | write deadline hi word
// ST_WR_CLO     | write deadline lo word
// ST_DONE       | one-cycle done pulse, done_err qualifies
module e203_subsys_clint_tmr_arm
  import e203_clint_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0200_0000,
  parameter int          MAX_RETRY = 3
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        arm_valid_i,
  output logic        arm_ready_o,
  input  logic [31:0] arm_interval_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        done_err_o,
  output logic        icb_cmd_valid_o,
  input  logic        icb_cmd_ready_i,
  output logic [31:0] icb_cmd_addr_o,
  output logic        icb_cmd_read_o,
  output logic [31:0] icb_cmd_wdata_o,
  output logic [3:0]  icb_cmd_wmask_o,
  input  logic        icb_rsp_valid_i,
  output logic        icb_rsp_ready_o,
  input  logic        icb_rsp_err_i,
  input  logic [31:0] icb_rsp_rdata_i
);

  localparam int RETRY_W = 8;

  arm_state_e         state_q;
  logic [31:0]        interval_q;
  logic [31:0]        hi1_q;
  logic [31:0]        lo_q;
  logic [63:0]        sum_q;
  logic [RETRY_W-1:0] retry_q;
  logic               arm_ready_q;
  logic               busy_q;
  logic               done_q;
  logic               done_err_q;

  logic        txn_start;
  logic [31:0] txn_addr;
  logic        txn_read;
  logic [31:0] txn_wdata;
  logic        txn_fin;
  logic        txn_err;
  logic [31:0] txn_rdata;
  logic [63:0] sum_d;
  logic        hi_moved;
  logic        retry_full;

  assign sum_d      = {hi1_q, lo_q} + {32'h0, interval_q};
  assign hi_moved   = (txn_rdata != hi1_q);
  assign retry_full = (retry_q >= RETRY_W'(MAX_RETRY));

  assign arm_ready_o = arm_ready_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign done_err_o  = done_err_q;

  // next command, launched in the cycle the previous response completes
  always_comb begin
    txn_start = 1'b0;
    txn_addr  = BASE_ADDR + CLINT_MTIME_HI_OFS;
    txn_read  = 1'b1;
    txn_wdata = 32'h0;
    case (state_q)
      ST_IDLE: txn_start = arm_valid_i & arm_ready_q;
      ST_RD_HI1: begin
        txn_start = txn_fin & ~txn_err;
        txn_addr  = BASE_ADDR + CLINT_MTIME_LO_OFS;
      end
      ST_RD_LO: txn_start = txn_fin & ~txn_err;
      ST_RD_HI2: begin
        if (txn_fin && !txn_err) begin
          if (hi_moved) begin
            txn_start = ~retry_full;
            txn_addr  = BASE_ADDR + CLINT_MTIME_LO_OFS;
          end else begin
            txn_start = 1'b1;
            txn_addr  = BASE_ADDR + CLINT_MTIMECMP_LO_OFS;
            txn_read  = 1'b0;
            txn_wdata = 32'hFFFF_FFFF;
          end
        end
      end
      ST_WR_CLO_MAX: begin
        txn_start = txn_fin & ~txn_err;
        txn_addr  = BASE_ADDR + CLINT_MTIMECMP_HI_OFS;
        txn_read  = 1'b0;
        txn_wdata = sum_q[63:32];
      end
      ST_WR_CHI: begin
        txn_start = txn_fin & ~txn_err;
        txn_addr  = BASE_ADDR + CLINT_MTIMECMP_LO_OFS;
        txn_read  = 1'b0;
        txn_wdata = sum_q[31:0];
      end
      default: ;
    endcase
  end

  // sequencer: sampling, retry bookkeeping, deadline capture and status outputs
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      interval_q  <= '0;
      hi1_q       <= '0;
      lo_q        <= '0;
      sum_q       <= '0;
      retry_q     <= '0;
      arm_ready_q <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      done_err_q  <= 1'b0;
    end else begin
      done_q     <= 1'b0;
      done_err_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (arm_valid_i && arm_ready_q) begin
            interval_q  <= arm_interval_i;
            retry_q     <= '0;
            arm_ready_q <= 1'b0;
            busy_q      <= 1'b1;
            state_q     <= ST_RD_HI1;
          end
        end
        ST_DONE: begin
          busy_q      <= 1'b0;
          arm_ready_q <= 1'b1;
          state_q     <= ST_IDLE;
        end
        default: begin
          if (txn_fin) begin
            if (txn_err) begin
              // a bus error abandons the sequence; mtimecmp stays as far as written
              state_q    <= ST_DONE;
              done_q     <= 1'b1;
              done_err_q <= 1'b1;
            end else begin
              case (state_q)
                ST_RD_HI1: begin
                  hi1_q   <= txn_rdata;
                  state_q <= ST_RD_LO;
                end
                ST_RD_LO: begin
                  lo_q    <= txn_rdata;
                  state_q <= ST_RD_HI2;
                end
                ST_RD_HI2: begin
                  if (hi_moved) begin
                    if (retry_full) begin
                      state_q    <= ST_DONE;
                      done_q     <= 1'b1;
                      done_err_q <= 1'b1;
                    end else begin
                      hi1_q   <= txn_rdata;
                      retry_q <= retry_q + RETRY_W'(1);
                      state_q <= ST_RD_LO;
                    end
                  end else begin
                    sum_q   <= sum_d;
                    state_q <= ST_WR_CLO_MAX;
                  end
                end
                ST_WR_CLO_MAX: state_q <= ST_WR_CHI;
                ST_WR_CHI:     state_q <= ST_WR_CLO;
                ST_WR_CLO: begin
                  state_q <= ST_DONE;
                  done_q  <= 1'b1;
                end
                default: state_q <= ST_IDLE;
              endcase
            end
          end
        end
      endcase
    end
  end

  e203_icb_single_txn u_txn (
    .clk_i           (clk_i),
    .rst_i           (rst_i),
    .start_i         (txn_start),
    .addr_i          (txn_addr),
    .read_i          (txn_read),
    .wdata_i         (txn_wdata),
    .fin_o           (txn_fin),
    .err_o           (txn_err),
    .rdata_o         (txn_rdata),
    .icb_cmd_valid_o (icb_cmd_valid_o),
    .icb_cmd_ready_i (icb_cmd_ready_i),
    .icb_cmd_addr_o  (icb_cmd_addr_o),
    .icb_cmd_read_o  (icb_cmd_read_o),
    .icb_cmd_wdata_o (icb_cmd_wdata_o),
    .icb_cmd_wmask_o (icb_cmd_wmask_o),
    .icb_rsp_valid_i (icb_rsp_valid_i),
    .icb_rsp_ready_o (icb_rsp_ready_o),
    .icb_rsp_err_i   (icb_rsp_err_i),
    .icb_rsp_rdata_i (icb_rsp_rdata_i)
  );

endmodule
